stack_alu: RTL and testbench

//  - Operation sequencer between the calc front-end and the stack.
//  - Accepts one op request (arithmetic or stack manipulation) and issues the pop/replace/push

---
 rtl/calc_pkg.sv | 19 +
 rtl/stack_alu_if.sv | 15 +
 rtl/calc_divider.sv | 44 ++++
 rtl/stack_alu.sv | 101 ++++++++++
 tb/tb_stack_alu.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: op codes, error codes and FSM state encodings shared by the stack ALU.
package calc_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MOD  = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_DUP  = 3'b110;
  localparam logic [2:0] OP_SWAP = 3'b111;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b00;
  localparam logic [1:0] ERR_DIVZERO   = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b10;
  localparam logic [1:0] ERR_STACK     = 2'b11;
  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_POP, S_WPOP, S_DIVW, S_EXEC,
    S_REPL, S_WREP, S_PUSH, S_WPSH, S_DONE, S_ERR
  } state_t;
endpackage

// File: rtl/stack_alu_if.sv
// stack_alu_if: front-end request/status and stack handshake signals of the stack ALU.
interface stack_alu_if #(parameter int WIDTH = 32, parameter int SIZE_W = 10);
  logic              op_req;
  logic [2:0]        op_code;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic              st_push, st_pop, st_replace;
  logic [WIDTH-1:0]  st_in, st_top;
  logic [SIZE_W-1:0] st_size;
  logic              st_err, st_vld;
  modport master(output op_req, op_code, st_top, st_size, st_err, st_vld,
                 input busy, done, err, err_code, st_push, st_pop, st_replace, st_in);
  modport slave(input op_req, op_code, st_top, st_size, st_err, st_vld,
                output busy, done, err, err_code, st_push, st_pop, st_replace, st_in);
endinterface

// File: rtl/calc_divider.sv
// calc_divider: iterative unsigned restoring divider, one quotient bit per cycle.
module calc_divider #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] r_quo, r_rem, r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH:0]   w_sh, w_sub;
  assign w_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_sub = w_sh - {1'b0, r_b};
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_a;
      r_rem  <= '0;
      r_b    <= i_b;
      r_cnt  <= CW'(WIDTH);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_quo  <= {r_quo[WIDTH-2:0], ~w_sub[WIDTH]};
      r_rem  <= w_sub[WIDTH] ? w_sh[WIDTH-1:0] : w_sub[WIDTH-1:0];
      r_cnt  <= r_cnt - CW'(1);
      r_busy <= r_cnt != CW'(1);
    end
  // done flags the edge on which the last quotient bit is written
  assign o_busy = r_busy;
  assign o_done = r_busy && r_cnt == CW'(1);
  assign o_quot = r_quo;
  assign o_rem  = r_rem;
endmodule

// File: rtl/stack_alu.sv
// stack_alu: sequences pop/replace/push handshakes to the stack for one arithmetic or stack op.
// Define CALC_DIV_EN to build the iterative divider for DIV/MOD; otherwise those ops are ILLEGAL.
module stack_alu
  import calc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIZE_W = 10
) (
  input logic       clk,
  input logic       reset_n,
  stack_alu_if.slave sif
);
  state_t            r_state, w_next;
  logic [2:0]        r_op;
  logic [WIDTH-1:0]  r_a, r_b, r_res, w_res;
  logic [1:0]        r_ecode, w_ecode;
  logic [SIZE_W-1:0] w_need;
  logic              w_divop, w_ill, w_div_wait;
  assign w_divop = r_op == OP_DIV || r_op == OP_MOD;
  assign w_need  = (r_op <= OP_MOD || r_op == OP_SWAP) ? SIZE_W'(2) : SIZE_W'(1);
`ifdef CALC_DIV_EN
  logic             w_div_start, w_div_busy, w_div_done;
  logic [WIDTH-1:0] w_quot, w_rem;
  assign w_ill       = 1'b0;
  assign w_div_start = r_state == S_WPOP && sif.st_vld && w_divop;
  assign w_div_wait  = w_div_busy && !w_div_done;
  calc_divider #(.WIDTH(WIDTH)) u_div (
    .clk(clk), .reset_n(reset_n), .i_start(w_div_start), .i_a(sif.st_top), .i_b(r_b),
    .o_busy(w_div_busy), .o_done(w_div_done), .o_quot(w_quot), .o_rem(w_rem)
  );
`else
  assign w_ill      = w_divop;
  assign w_div_wait = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_ecode <= '0;
    end else begin
      if (r_state == S_IDLE && sif.op_req) r_op <= sif.op_code;
      if (r_state == S_CHECK) r_b <= sif.st_top;
      if (r_state == S_WPOP && sif.st_vld) r_a <= sif.st_top;
      if (r_state == S_EXEC) r_res <= w_res;
      if (w_next == S_ERR) r_ecode <= w_ecode;
    end
  always_comb begin
    w_next  = r_state;
    w_ecode = ERR_STACK;
    case (r_state)
      S_IDLE:  w_next = sif.op_req ? S_CHECK : S_IDLE;
      S_CHECK: begin
        w_next  = w_ill || sif.st_size < w_need || (w_divop && sif.st_top == '0) ? S_ERR :
                  r_op == OP_DUP ? S_PUSH : S_POP;
        w_ecode = w_ill ? ERR_ILLEGAL : sif.st_size < w_need ? ERR_UNDERFLOW : ERR_DIVZERO;
      end
      S_POP:   w_next = S_WPOP;
      S_WPOP:  if (sif.st_vld) w_next = r_op == OP_POP ? S_DONE : w_divop ? S_DIVW : S_EXEC;
      S_DIVW:  w_next = w_div_wait ? S_DIVW : S_EXEC;
      S_EXEC:  w_next = S_REPL;
      S_REPL:  w_next = S_WREP;
      S_WREP:  if (sif.st_vld) w_next = r_op == OP_SWAP ? S_PUSH : S_DONE;
      S_PUSH:  w_next = S_WPSH;
      S_WPSH:  if (sif.st_vld) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (sif.st_err && r_state != S_IDLE && r_state != S_DONE && r_state != S_ERR) begin
      w_next  = S_ERR;
      w_ecode = ERR_STACK;
    end
  end
  // SWAP passes through EXEC so that REPL writes the old top back
  always_comb begin
    w_res = r_b;
    case (r_op)
      OP_ADD:  w_res = r_a + r_b;
      OP_SUB:  w_res = r_a - r_b;
      OP_MUL:  w_res = r_a * r_b;
`ifdef CALC_DIV_EN
      OP_DIV:  w_res = w_quot;
      OP_MOD:  w_res = w_rem;
`endif
      default: w_res = r_b;
    endcase
  end
  always_comb begin
    sif.busy       = reset_n && r_state != S_IDLE;
    sif.done       = reset_n && r_state == S_DONE;
    sif.err        = reset_n && r_state == S_ERR;
    sif.err_code   = (reset_n && r_state == S_ERR) ? r_ecode : '0;
    sif.st_pop     = reset_n && r_state == S_POP;
    sif.st_replace = reset_n && r_state == S_REPL;
    sif.st_push    = reset_n && r_state == S_PUSH;
    sif.st_in      = !reset_n ? '0 : r_state == S_PUSH ? (r_op == OP_DUP ? r_b : r_a) : r_res;
  end
endmodule

// File: tb/tb_stack_alu.sv
// tb_stack_alu: directed checks of stack_alu against a small behavioural stack.
module tb_stack_alu;
  import calc_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  stack_alu_if #(.WIDTH(32), .SIZE_W(10)) sif();
  stack_alu #(.WIDTH(32), .SIZE_W(10)) dut(.clk(clk), .reset_n(reset_n), .sif(sif));
  logic [31:0] stk [0:15];
  int depth = 0, pops = 0, pushes = 0, repls = 0, dones = 0;
  logic [31:0] last_repl = '0;
  logic ld = 1'b0, hold_vld = 1'b0, force_err = 1'b0;
  int ld_n = 0;
  logic [31:0] ld0 = '0, ld1 = '0;
  int passes = 0, fails = 0, total = 0, lat = 0;
  logic got_done, got_err;
  logic [1:0] got_code;
  assign sif.st_top  = depth > 0 ? stk[4'(depth - 1)] : '0;
  assign sif.st_size = 10'(depth);
  assign sif.st_vld  = !hold_vld;
  assign sif.st_err  = force_err;
  always @(posedge clk)
    if (ld) begin
      depth <= ld_n; stk[0] <= ld0; stk[1] <= ld1;
      pops <= 0; pushes <= 0; repls <= 0; dones <= 0;
    end else begin
      if (sif.st_pop) begin depth <= depth - 1; pops <= pops + 1; end
      if (sif.st_push) begin stk[4'(depth)] <= sif.st_in; depth <= depth + 1; pushes <= pushes + 1; end
      if (sif.st_replace) begin stk[4'(depth - 1)] <= sif.st_in; last_repl <= sif.st_in; repls <= repls + 1; end
      if (sif.done) dones <= dones + 1;
    end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input int n, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk); ld_n = n; ld0 = a; ld1 = b; ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask
  task automatic do_op(input logic [2:0] code, input bit hold);
    sif.op_code = code; sif.op_req = 1'b1;
    @(negedge clk); if (!hold) sif.op_req = 1'b0;
    lat = 1;
    while (!(sif.done || sif.err) && lat < 100) begin @(negedge clk); lat++; end
    got_done = sif.done; got_err = sif.err; got_code = sif.err_code;
    @(negedge clk); sif.op_req = 1'b0;
  endtask
  task automatic start_op(input logic [2:0] code);
    @(negedge clk); sif.op_code = code; sif.op_req = 1'b1;
    @(negedge clk); sif.op_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    sif.op_req = 1'b0; sif.op_code = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_busy", sif.busy, 0);
    check("rst_done_err", {sif.done, sif.err, sif.err_code}, 0);
    check("rst_strobes", {sif.st_push, sif.st_pop, sif.st_replace}, 0);
    check("rst_st_in", sif.st_in, 0);
    load(2, 7, 5); do_op(OP_ADD, 0);
    check("add_done", got_done, 1);
    check("add_lat", lat, 7);
    check("add_repl", last_repl, 12);
    check("add_size", depth, 1);
    check("add_top", sif.st_top, 12);
    check("add_busy_after", sif.busy, 0);
    load(2, 3, 5); do_op(OP_SUB, 0);
    check("sub_repl", last_repl, 32'hFFFF_FFFE);
    check("sub_pops", pops, 1);
    load(2, 32'h1_0000, 32'h1_0000); do_op(OP_MUL, 0);
    check("mul_done", got_done, 1);
    check("mul_repl", last_repl, 0);
    load(1, 4, 0); do_op(OP_SWAP, 0);
    check("uf_err", got_err, 1);
    check("uf_code", got_code, ERR_UNDERFLOW);
    check("uf_lat", lat, 2);
    check("uf_strobes", pops + pushes + repls, 0);
    load(2, 9, 2); do_op(OP_SWAP, 0);
    check("swap_done", got_done, 1);
    check("swap_lat", lat, 9);
    check("swap_top", sif.st_top, 9);
    check("swap_below", stk[0], 2);
    check("swap_size", depth, 2);
    check("swap_strobes", {8'(pops), 8'(repls), 8'(pushes)}, 24'h010101);
    load(2, 4, 6); do_op(OP_POP, 0);
    check("pop_lat", lat, 4);
    check("pop_top", sif.st_top, 4);
    check("pop_size", depth, 1);
    load(1, 8, 0); do_op(OP_DUP, 0);
    check("dup_lat", lat, 4);
    check("dup_size", depth, 2);
    check("dup_top", sif.st_top, 8);
    load(2, 1, 2); do_op(OP_ADD, 1);
    check("hold_busy_after", sif.busy, 0);
    check("hold_dones", dones, 1);
    check("hold_pops", pops, 1);
`ifdef CALC_DIV_EN
    load(2, 17, 5); do_op(OP_DIV, 0);
    check("div_done", got_done, 1);
    check("div_lat", lat, 39);
    check("div_repl", last_repl, 3);
    load(2, 17, 5); do_op(OP_MOD, 0);
    check("mod_repl", last_repl, 2);
    load(2, 4, 0); do_op(OP_DIV, 0);
    check("dz_err", got_err, 1);
    check("dz_code", got_code, ERR_DIVZERO);
    check("dz_size", depth, 2);
    check("dz_strobes", pops + repls, 0);
`else
    load(2, 17, 5); do_op(OP_DIV, 0);
    check("ill_err", got_err, 1);
    check("ill_code", got_code, ERR_ILLEGAL);
    check("ill_lat", lat, 2);
    check("ill_size", depth, 2);
`endif
    load(2, 1, 2); hold_vld = 1'b1; start_op(OP_ADD);
    check("abort_busy", sif.busy, 1);
    force_err = 1'b1;
    @(negedge clk);
    check("abort_err", sif.err, 1);
    check("abort_code", sif.err_code, ERR_STACK);
    force_err = 1'b0; hold_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_idle", sif.busy, 0);
    check("abort_repls", repls, 0);
    load(2, 1, 2); hold_vld = 1'b1; start_op(OP_ADD);
    reset_n = 1'b0;
    @(negedge clk);
    check("rstmid_busy", sif.busy, 0);
    check("rstmid_strobes", {sif.st_push, sif.st_pop, sif.st_replace}, 0);
    reset_n = 1'b1; hold_vld = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_dones", dones, 0);
    check("rstmid_repls", repls, 0);
    check("rstmid_idle", sif.busy, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
